target_box_detect: RTL and testbench
====================================

Name: target_box_detect

Overview:
- Sits directly downstream of the binary dilation stage; consumes its de/hsync/vsync/data stream.
- Per frame: finds the bounding box of all white (non-zero) pixels and counts them; latches the result at the next frame boundary.
- Passes the video through with 1-clk latency, drawing the previous frame's box as a BOX_COLOR outline for display/debug.

Parameters:
- H_DISP, 12'd480, active pixels per line.
- V_DISP, 12'd272, active lines per frame.
- MIN_PIX, 19'd16, minimum white-pixel count for a box to be reported valid.
- BOX_COLOR, 8'h80, data value written on box outline pixels.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- dilate_de  input  1  pixel data enable.
- dilate_hsync  input  1  line sync, passed through.
- dilate_vsync  input  1  frame sync, active-high pulse.
- dilate_data  input  8  binary pixel, 8'h00 black, otherwise white.
- box_de  output  1  dilate_de delayed 1 clk.
- box_hsync  output  1  dilate_hsync delayed 1 clk.
- box_vsync  output  1  dilate_vsync delayed 1 clk.
- box_data  output  8  pixel delayed 1 clk, replaced by BOX_COLOR on outline.
- box_x_min, box_x_max  output  12  latched horizontal extent.
- box_y_min, box_y_max  output  12  latched vertical extent.
- box_pix_cnt  output  19  latched white-pixel count, saturating at 19'h7FFFF.
- box_found  output  1  latched box is valid (count >= MIN_PIX).
- box_upd  output  1  one-clk pulse when latched outputs update.

Behaviour:
- Reset: all outputs 0; x_cnt/y_cnt 0; accumulators cleared; armed flag 0.
- Position tracking:
  - x_cnt increments on each de=1 cycle and clears on the de falling edge.
  - y_cnt increments on each de falling edge and clears on the vsync rising edge.
  - Both counters saturate at H_DISP-1 / V_DISP-1. Pixels seen while a counter is saturated are not accumulated.
- Accumulation: when de=1, data!=0 and the pixel is in range:
  - x_min/y_min take the minimum; x_max/y_max take the maximum.
  - cnt increments, saturating.
  - Running values initialise to x_min=H_DISP-1, y_min=V_DISP-1, max=0, cnt=0.
- Frame boundary is the vsync rising edge (registered compare, 1-clk detect). The same cycle:
  - If armed=1: copy running min/max/cnt to the latched outputs. box_found <= (cnt >= MIN_PIX). Pulse box_upd. The latched min/max are copied even when box_found=0.
  - Always: reinitialise the running values, clear y_cnt, set armed=1.
  - The first vsync edge after reset only arms; no box_upd. This prevents reporting a partial frame.
- A de=1 pixel coincident with a vsync rising edge is discarded. Reinit has priority over accumulation.
- Overlay, evaluated on the current input position using the latched box:
  - Applies only if box_found=1 and de=1.
  - Outline condition: ((x==x_min or x==x_max) and y_min<=y<=y_max) or ((y==y_min or y==y_max) and x_min<=x<=x_max).
  - Outline pixels output BOX_COLOR; all others pass dilate_data unchanged.
  - When de=0, box_data = 8'h00.
- Latency:
  - Video path: exactly 1 clk for de/hsync/vsync/data.
  - Statistics: box_upd fires 2 clk after the vsync rising edge at the input.
- Latched outputs hold until the next update or reset. A reset mid-frame discards all partial statistics.

Decomposition:
- Shared package/include: COORD_W=12, CNT_W=19, and the CNT_SAT constant.
- No sub-module. Edge detect, counters, accumulators and overlay fit in one file of roughly 200 lines.

Test Plan:
All scenarios use H_DISP=16, V_DISP=8, MIN_PIX=4.
- Reset, then two frames with a white block at x=3..6, y=2..4 -> first vsync gives no box_upd. Second: box_upd=1 for 1 clk with x 3..6, y 2..4, cnt=12, box_found=1.
- Frame with only 3 white pixels -> box_upd pulses with cnt=3 and box_found=0. The following frame shows no overlay (box_data equals the input delayed 1 clk).
- Third frame after the block frame -> box_data=8'h80 at (3,2),(6,2),(3,4),(6,4) and along the edges; interior (4,3) and exterior (0,0) pass through.
- All-white frame -> x 0..15, y 0..7, cnt=128. A line with 20 de cycles -> pixels 16..19 are ignored and x_max=15.
- rst_n low mid-frame, then full frames -> no box_upd until the second vsync edge; outputs stay 0 in between.
- Pixel with de=1 and data=ff on the same cycle as the vsync rising edge -> excluded from both frames' statistics.
- All scenarios: box_de/hsync/vsync equal the inputs delayed exactly 1 clk.

Source files
------------

// File: rtl/target_box_detect_pkg.sv
// -----------------------------------------------------------------------------
// target_box_detect_pkg
// Shared widths, types and helpers for the target bounding-box detector.
//   COORD_W     : pixel coordinate width (x/y counters, box extents)
//   CNT_W       : white-pixel counter width
//   CNT_SAT     : saturation value of the white-pixel counter
//   box_stats_t : running (or latched) bounding box plus pixel count
// -----------------------------------------------------------------------------
package target_box_detect_pkg;

    localparam int COORD_W = 12;
    localparam int CNT_W   = 19;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam cnt_t CNT_SAT = 19'h7FFFF;

    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
        cnt_t   cnt;
    } box_stats_t;

    // Increment that sticks at CNT_SAT instead of wrapping to zero.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == CNT_SAT) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/target_box_detect.sv
// -----------------------------------------------------------------------------
// target_box_detect
// Finds the bounding box and white-pixel count of each binary frame coming out
// of the dilation stage, latches the result at the next frame boundary, and
// passes the video through with one clock of latency while drawing the last
// reported box as an outline.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   dilate_de/hsync/vsync/data input video (data 8'h00 = black, else white)
//   box_de/hsync/vsync/data    video delayed 1 clk, outline pixels replaced
//                              by BOX_COLOR
//   box_x_min/x_max            latched horizontal extent
//   box_y_min/y_max            latched vertical extent
//   box_pix_cnt                latched white-pixel count (saturating)
//   box_found                  latched count reached MIN_PIX
//   box_upd                    one-clk pulse when the latched outputs change
// -----------------------------------------------------------------------------
module target_box_detect
    import target_box_detect_pkg::*;
#(
    parameter coord_t     H_DISP    = 12'd480,
    parameter coord_t     V_DISP    = 12'd272,
    parameter cnt_t       MIN_PIX   = 19'd16,
    parameter logic [7:0] BOX_COLOR = 8'h80
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dilate_de,
    input  logic               dilate_hsync,
    input  logic               dilate_vsync,
    input  logic [7:0]         dilate_data,
    output logic               box_de,
    output logic               box_hsync,
    output logic               box_vsync,
    output logic [7:0]         box_data,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic [CNT_W-1:0]   box_pix_cnt,
    output logic               box_found,
    output logic               box_upd
);

    localparam coord_t X_LAST = H_DISP - 12'd1;
    localparam coord_t Y_LAST = V_DISP - 12'd1;

    // Running values at the start of every frame: min at the far corner,
    // max at the origin, so the first white pixel overwrites both.
    localparam box_stats_t RUN_INIT = '{
        x_min: X_LAST,
        x_max: '0,
        y_min: Y_LAST,
        y_max: '0,
        cnt:   '0
    };

    // Position of the pixel currently on the input. The overflow flags mark
    // pixels beyond the active area, which are neither counted nor outlined.
    coord_t     x_cnt;
    coord_t     y_cnt;
    logic       x_ovf;
    logic       y_ovf;

    logic       vs_rise;
    logic       de_fall;
    logic       frame_edge;
    logic       armed;
    logic       in_range;
    logic       pix_hit;
    box_stats_t run;

    logic       in_cols;
    logic       in_rows;
    logic       on_col;
    logic       on_row;
    logic       outline;
    logic [7:0] data_next;

    // box_vsync / box_de are the 1-clk delayed copies of the inputs, so they
    // double as the history registers for edge detection.
    assign vs_rise  = dilate_vsync & ~box_vsync;
    assign de_fall  = ~dilate_de & box_de;
    assign in_range = ~x_ovf & ~y_ovf;

    // A pixel on the input vsync edge, or on the cycle the registered edge
    // reinitialises the accumulators, belongs to neither frame.
    assign pix_hit = dilate_de && (dilate_data != 8'h00) && in_range &&
                     !vs_rise && !frame_edge;

    // ------------------------------------------------------------------
    // Outline overlay, using the previously latched box
    // ------------------------------------------------------------------
    assign in_cols = (x_cnt >= box_x_min) && (x_cnt <= box_x_max);
    assign in_rows = (y_cnt >= box_y_min) && (y_cnt <= box_y_max);
    assign on_col  = (x_cnt == box_x_min) || (x_cnt == box_x_max);
    assign on_row  = (y_cnt == box_y_min) || (y_cnt == box_y_max);
    assign outline = box_found && dilate_de && in_range &&
                     ((on_col && in_rows) || (on_row && in_cols));

    // NOTE: combinational blocks assign a default first and use blocking
    // assignments, so every path drives data_next and no latch is inferred.
    always_comb begin
        data_next = dilate_data;
        if (!dilate_de) begin
            data_next = 8'h00;
        end else if (outline) begin
            data_next = BOX_COLOR;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_de    <= 1'b0;
            box_hsync <= 1'b0;
            box_vsync <= 1'b0;
            box_data  <= 8'h00;
        end else begin
            box_de    <= dilate_de;
            box_hsync <= dilate_hsync;
            box_vsync <= dilate_vsync;
            box_data  <= data_next;
        end
    end

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            x_ovf <= 1'b0;
            y_cnt <= '0;
            y_ovf <= 1'b0;
        end else begin
            if (dilate_de) begin
                if (x_cnt == X_LAST) begin
                    x_ovf <= 1'b1;
                end else begin
                    x_cnt <= x_cnt + 12'd1;
                end
            end else if (de_fall) begin
                x_cnt <= '0;
                x_ovf <= 1'b0;
            end

            // Frame clear wins over a line end landing on the same cycle.
            if (vs_rise || frame_edge) begin
                y_cnt <= '0;
                y_ovf <= 1'b0;
            end else if (de_fall) begin
                if (y_cnt == Y_LAST) begin
                    y_ovf <= 1'b1;
                end else begin
                    y_cnt <= y_cnt + 12'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulation and frame-boundary latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_edge  <= 1'b0;
            armed       <= 1'b0;
            run         <= RUN_INIT;
            box_x_min   <= '0;
            box_x_max   <= '0;
            box_y_min   <= '0;
            box_y_max   <= '0;
            box_pix_cnt <= '0;
            box_found   <= 1'b0;
            box_upd     <= 1'b0;
        end else begin
            frame_edge <= vs_rise;
            box_upd    <= 1'b0;

            if (frame_edge) begin
                // The frame before the first edge after reset may be partial,
                // so that edge only arms the reporting.
                if (armed) begin
                    box_x_min   <= run.x_min;
                    box_x_max   <= run.x_max;
                    box_y_min   <= run.y_min;
                    box_y_max   <= run.y_max;
                    box_pix_cnt <= run.cnt;
                    box_found   <= (run.cnt >= MIN_PIX);
                    box_upd     <= 1'b1;
                end
                run   <= RUN_INIT;
                armed <= 1'b1;
            end else if (pix_hit) begin
                if (x_cnt < run.x_min) run.x_min <= x_cnt;
                if (x_cnt > run.x_max) run.x_max <= x_cnt;
                if (y_cnt < run.y_min) run.y_min <= y_cnt;
                if (y_cnt > run.y_max) run.y_max <= y_cnt;
                run.cnt <= cnt_sat_inc(run.cnt);
            end
        end
    end

endmodule

// File: tb/tb_target_box_detect.sv
// -----------------------------------------------------------------------------
// tb_target_box_detect
// Drives frames into target_box_detect (H_DISP=16, V_DISP=8, MIN_PIX=4) and
// compares every output, every cycle, against a frame-level reference model
// that stores the accepted white pixels of each frame in a queue and derives
// the box from them. A table of frames with hand-computed boxes, plus hand
// sequences for arming, the vsync-coincident pixel and mid-frame reset, adds
// explicit checks on top.
// -----------------------------------------------------------------------------
module tb_target_box_detect;
    import target_box_detect_pkg::*;

    localparam int HI   = 16;
    localparam int VI   = 8;
    localparam int MINI = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               dilate_de = 1'b0;
    logic               dilate_hsync = 1'b0;
    logic               dilate_vsync = 1'b0;
    logic [7:0]         dilate_data = 8'h00;
    logic               box_de, box_hsync, box_vsync;
    logic [7:0]         box_data;
    logic [COORD_W-1:0] box_x_min, box_x_max, box_y_min, box_y_max;
    logic [CNT_W-1:0]   box_pix_cnt;
    logic               box_found, box_upd;

    always #5 clk = ~clk;

    target_box_detect #(
        .H_DISP   (12'(HI)),
        .V_DISP   (12'(VI)),
        .MIN_PIX  (19'(MINI)),
        .BOX_COLOR(8'h80)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dilate_de   (dilate_de),
        .dilate_hsync(dilate_hsync),
        .dilate_vsync(dilate_vsync),
        .dilate_data (dilate_data),
        .box_de      (box_de),
        .box_hsync   (box_hsync),
        .box_vsync   (box_vsync),
        .box_data    (box_data),
        .box_x_min   (box_x_min),
        .box_x_max   (box_x_max),
        .box_y_min   (box_y_min),
        .box_y_max   (box_y_max),
        .box_pix_cnt (box_pix_cnt),
        .box_found   (box_found),
        .box_upd     (box_upd)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  mx, my;                       // pixel index in line, line index in frame
    bit  m_prev_vs, m_prev_de, m_pending, m_armed;
    int  m_xmin, m_xmax, m_ymin, m_ymax, m_cnt;
    bit  m_found;
    int  qx[$];
    int  qy[$];
    bit  e_de, e_hs, e_vs, e_upd;
    logic [7:0] e_data;

    function automatic logic [67:0] model_lat();
        return {12'(m_xmin), 12'(m_xmax), 12'(m_ymin), 12'(m_ymax), 19'(m_cnt), m_found};
    endfunction

    function automatic logic [67:0] dut_lat();
        return {box_x_min, box_x_max, box_y_min, box_y_max, box_pix_cnt, box_found};
    endfunction

    task automatic model_reset();
        mx = 0; my = 0;
        m_prev_vs = 0; m_prev_de = 0; m_pending = 0; m_armed = 0;
        m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_cnt = 0; m_found = 0;
        qx.delete(); qy.delete();
        e_de = 0; e_hs = 0; e_vs = 0; e_upd = 0; e_data = 8'h00;
    endtask

    task automatic model_report();
        int xmn = HI - 1, xmx = 0, ymn = VI - 1, ymx = 0;
        foreach (qx[i]) begin
            if (qx[i] < xmn) xmn = qx[i];
            if (qx[i] > xmx) xmx = qx[i];
            if (qy[i] < ymn) ymn = qy[i];
            if (qy[i] > ymx) ymx = qy[i];
        end
        m_xmin = xmn; m_xmax = xmx; m_ymin = ymn; m_ymax = ymx;
        m_cnt   = (qx.size() > 32'h7FFFF) ? 32'h7FFFF : qx.size();
        m_found = (m_cnt >= MINI);
    endtask

    task automatic model_step(input bit de, input bit hs, input bit vs, input logic [7:0] d);
        bit inr, edge_now, on_outline;
        if (!rst_n) begin
            model_reset();
            return;
        end
        inr = (mx < HI) && (my < VI);
        on_outline = m_found && de && inr &&
            ((((mx == m_xmin) || (mx == m_xmax)) && (my >= m_ymin) && (my <= m_ymax)) ||
             (((my == m_ymin) || (my == m_ymax)) && (mx >= m_xmin) && (mx <= m_xmax)));
        e_de = de; e_hs = hs; e_vs = vs;
        e_data = !de ? 8'h00 : (on_outline ? 8'h80 : d);
        e_upd = 0;
        edge_now = vs && !m_prev_vs;
        if (m_pending) begin
            if (m_armed) begin
                model_report();
                e_upd = 1;
            end
            qx.delete(); qy.delete();
            m_armed = 1;
        end else if (de && d != 8'h00 && inr && !edge_now) begin
            qx.push_back(mx); qy.push_back(my);
        end
        if (de) mx++;
        else if (m_prev_de) mx = 0;
        if (edge_now || m_pending) my = 0;
        else if (!de && m_prev_de) my++;
        m_pending = edge_now; m_prev_vs = vs; m_prev_de = de;
    endtask

    // ---------------- stimulus helpers ----------------
    logic [7:0]  cap [VI][HI];         // box_data seen at each in-range position
    int          upd_cnt, first_upd, step_idx;
    logic [67:0] snap;

    task automatic step(input bit de, input bit hs, input bit vs, input logic [7:0] d);
        int px = mx, py = my;
        bit inr = (mx < HI) && (my < VI);
        dilate_de = de; dilate_hsync = hs; dilate_vsync = vs; dilate_data = d;
        model_step(de, hs, vs, d);
        @(negedge clk);
        check("cycle", {box_de, box_hsync, box_vsync, box_data, box_upd, dut_lat()},
                       {e_de, e_hs, e_vs, e_data, e_upd, model_lat()});
        if (de && inr && rst_n) cap[py][px] = box_data;
        if (box_upd) begin
            upd_cnt++;
            if (first_upd == 0) first_upd = step_idx;
            snap = dut_lat();
        end
        step_idx++;
    endtask

    task automatic frame_lines(input int x0, input int x1, input int y0, input int y1,
                               input int len, input int nl, input bit rnd);
        for (int y = 0; y < nl; y++) begin
            step(0, 1, 0, 8'h00);
            step(0, 0, 0, 8'h00);
            step(0, 0, 0, 8'h00);
            for (int x = 0; x < len; x++) begin
                logic [7:0] d;
                if (rnd) d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                else     d = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 8'hff : 8'h00;
                step(1, 0, 0, d);
            end
            step(0, 0, 0, 8'h00);
            step(0, 0, 0, 8'h00);
        end
    endtask

    // vsync pulse; optional white de pixel on the rising-edge cycle.
    task automatic do_vsync(input bit coinc, output int n_upd, output int lat, output logic [67:0] s);
        upd_cnt = 0; first_upd = 0; step_idx = 1; snap = '0;
        for (int k = 0; k < 3; k++) begin
            if (coinc && k == 0) step(1, 0, 1, 8'hff);
            else                 step(0, 0, 1, 8'h00);
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h00);
        n_upd = upd_cnt; lat = first_upd; s = snap;
    endtask

    typedef struct {
        int          x0, x1, y0, y1, len;
        logic [67:0] exp;   // {x_min, x_max, y_min, y_max, cnt, found}
    } vec_t;

    localparam logic [67:0] BLOCK_BOX = {12'd3, 12'd6, 12'd2, 12'd4, 19'd12, 1'b1};
    localparam logic [67:0] EMPTY_BOX = {12'd15, 12'd0, 12'd7, 12'd0, 19'd0, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        int          n_upd, lat;
        logic [67:0] s;

        tbl[0] = '{x0: 3,  x1: 6,  y0: 2, y1: 4, len: 16, exp: BLOCK_BOX};
        tbl[1] = '{x0: 5,  x1: 7,  y0: 1, y1: 1, len: 16, exp: {12'd5, 12'd7, 12'd1, 12'd1, 19'd3, 1'b0}};
        tbl[2] = '{x0: 0,  x1: 19, y0: 0, y1: 7, len: 20, exp: {12'd0, 12'd15, 12'd0, 12'd7, 19'd128, 1'b1}};
        tbl[3] = '{x0: 15, x1: 15, y0: 7, y1: 7, len: 16, exp: {12'd15, 12'd15, 12'd7, 12'd7, 19'd1, 1'b0}};
        tbl[4] = '{x0: 0,  x1: 1,  y0: 0, y1: 1, len: 16, exp: {12'd0, 12'd1, 12'd0, 12'd1, 19'd4, 1'b1}};
        tbl[5] = '{x0: 1,  x1: 0,  y0: 0, y1: 0, len: 16, exp: EMPTY_BOX};

        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h00);
        check("reset_outputs", {box_de, box_hsync, box_vsync, box_data, box_upd, dut_lat()}, '0);
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00);

        // First edge after reset only arms.
        frame_lines(3, 6, 2, 4, 16, VI, 0);
        do_vsync(0, n_upd, lat, s);
        check("arm_no_upd", 128'(n_upd), 128'd0);

        for (int i = 0; i < 6; i++) begin
            frame_lines(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].len, VI, 0);
            if (i == 1) begin
                // Block box from frame 0 drawn over frame 1.
                check("ovl_3_2", 128'(cap[2][3]), 128'h80);
                check("ovl_6_2", 128'(cap[2][6]), 128'h80);
                check("ovl_3_4", 128'(cap[4][3]), 128'h80);
                check("ovl_6_4", 128'(cap[4][6]), 128'h80);
                check("ovl_5_2", 128'(cap[2][5]), 128'h80);
                check("ovl_3_3", 128'(cap[3][3]), 128'h80);
                check("ovl_in_4_3", 128'(cap[3][4]), 128'h00);
                check("ovl_out_0_0", 128'(cap[0][0]), 128'h00);
                check("ovl_out_5_1", 128'(cap[1][5]), 128'hff);
            end
            if (i == 2) begin
                // Frame 1 had too few pixels: no outline on the all-white frame.
                check("noovl_3_2", 128'(cap[2][3]), 128'hff);
                check("noovl_6_4", 128'(cap[4][6]), 128'hff);
            end
            do_vsync(0, n_upd, lat, s);
            check($sformatf("tbl%0d_upd_once", i), 128'(n_upd), 128'd1);
            check($sformatf("tbl%0d_latency", i), 128'(lat), 128'd2);
            check($sformatf("tbl%0d_box", i), 128'(s), 128'(tbl[i].exp));
        end

        // White pixel on the vsync rising edge belongs to neither frame.
        frame_lines(2, 3, 0, 1, 16, 2, 0);
        do_vsync(1, n_upd, lat, s);
        check("coinc_prev_box", 128'(s), 128'({12'd2, 12'd3, 12'd0, 12'd1, 19'd4, 1'b1}));
        frame_lines(1, 0, 0, 0, 16, VI, 0);
        do_vsync(0, n_upd, lat, s);
        check("coinc_next_box", 128'(s), 128'(EMPTY_BOX));

        // Reset in the middle of a line.
        frame_lines(3, 6, 2, 4, 16, 3, 0);
        step(0, 1, 0, 8'h00);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 8'hff);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h00);
        check("rst_mid_zero", {box_upd, dut_lat()}, '0);
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00);
        frame_lines(3, 6, 2, 4, 16, VI, 0);
        do_vsync(0, n_upd, lat, s);
        check("rst_arm_no_upd", 128'(n_upd), 128'd0);
        check("rst_held_zero", 128'(dut_lat()), 128'd0);
        frame_lines(3, 6, 2, 4, 16, VI, 0);
        do_vsync(0, n_upd, lat, s);
        check("rst_upd_once", 128'(n_upd), 128'd1);
        check("rst_box", 128'(s), 128'(BLOCK_BOX));

        // Random frames of varying line length and line count.
        for (int f = 0; f < 6; f++) begin
            frame_lines(0, 0, 0, 0, $urandom_range(12, 20), $urandom_range(6, 9), 1);
            do_vsync(0, n_upd, lat, s);
            check($sformatf("rnd%0d_upd_once", f), 128'(n_upd), 128'd1);
            check($sformatf("rnd%0d_box", f), 128'(s), 128'(model_lat()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
